// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the machine/debug CSR file: CSR address map,
// reset values, writable-bit masks, the register snapshot used by the read
// decoder, and the read-decode helper itself.
// ---------------------------------------------------------------------------
package csr_pkg;

    // Architectural CSR addresses (only address bits [11:0] are decoded).
    typedef enum logic [11:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MISA      = 12'h301,
        CSR_MIE       = 12'h304,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MIP       = 12'h344,
        CSR_DCSR      = 12'h7B0,
        CSR_DPC       = 12'h7B1,
        CSR_DSCRATCH0 = 12'h7B2,
        CSR_DSCRATCH1 = 12'h7B3,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82,
        CSR_MHARTID   = 12'hF14
    } csr_addr_e;

    // Which port won write arbitration this cycle.
    typedef enum logic [1:0] {
        WR_NONE,
        WR_PIPE,
        WR_DBG,
        WR_EXCEP
    } wr_src_e;

    // Read-only constants.
    localparam logic [31:0] MISA_VALUE    = 32'h4000_0104;
    localparam logic [31:0] MHARTID_VALUE = 32'h0000_0000;

    // mstatus: only MIE (3) and MPIE (7) are writable, MPP (12:11) is fixed to M.
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;

    // mie: MSIE (3), MTIE (7), MEIE (11).
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;

    // mepc/dpc are always halfword-or-better aligned.
    localparam logic [31:0] EPC_WMASK     = 32'hFFFF_FFFE;

    // dcsr: xdebugver (31:28) = 4 and prv (1:0) = 3 are fixed. Pipeline and
    // debug ports may only touch ebreakm (15) and step (2); the exception
    // port owns the rest of the non-fixed field (cause, etc.).
    localparam logic [31:0] DCSR_RESET     = 32'h4000_0003;
    localparam logic [31:0] DCSR_FIXED     = 32'h4000_0003;
    localparam logic [31:0] DCSR_DBG_WMASK = 32'h0000_8004;
    localparam logic [31:0] DCSR_EXC_WMASK = 32'h0FFF_FFFC;

    // Snapshot of every readable CSR, handed to the read decoder.
    typedef struct packed {
        logic [31:0] mstatus;
        logic [31:0] mie;
        logic [31:0] mtvec;
        logic [31:0] mscratch;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mip;
        logic [63:0] mcycle;
        logic [63:0] minstret;
        logic [31:0] dcsr;
        logic [31:0] dpc;
        logic [31:0] dscratch0;
        logic [31:0] dscratch1;
    } csr_regs_t;

    // Combinational read decode; unmapped addresses read as zero.
    function automatic logic [31:0] csr_read(input logic [11:0] addr,
                                             input csr_regs_t   regs);
        logic [31:0] rdata;
        rdata = '0;
        case (addr)
            CSR_MSTATUS:   rdata = regs.mstatus;
            CSR_MISA:      rdata = MISA_VALUE;
            CSR_MIE:       rdata = regs.mie;
            CSR_MTVEC:     rdata = regs.mtvec;
            CSR_MSCRATCH:  rdata = regs.mscratch;
            CSR_MEPC:      rdata = regs.mepc;
            CSR_MCAUSE:    rdata = regs.mcause;
            CSR_MIP:       rdata = regs.mip;
            CSR_DCSR:      rdata = regs.dcsr;
            CSR_DPC:       rdata = regs.dpc;
            CSR_DSCRATCH0: rdata = regs.dscratch0;
            CSR_DSCRATCH1: rdata = regs.dscratch1;
            CSR_MCYCLE:    rdata = regs.mcycle[31:0];
            CSR_MCYCLEH:   rdata = regs.mcycle[63:32];
            CSR_MINSTRET:  rdata = regs.minstret[31:0];
            CSR_MINSTRETH: rdata = regs.minstret[63:32];
            CSR_MHARTID:   rdata = MHARTID_VALUE;
            default:       rdata = '0;
        endcase
        return rdata;
    endfunction

endpackage

// File: rtl/csr_file_if.sv
// ---------------------------------------------------------------------------
// csr_file_if
// Access ports of the CSR file bundled together:
//   pipeline port  : pipe_we_i, pipe_waddr_i, pipe_wdata_i, pipe_raddr_i -> pipe_rdata_o
//   exception port : excep_we_i, excep_waddr_i, excep_wdata_i
//   debug port     : dbg_we_i, dbg_addr_i, dbg_wdata_i -> dbg_rdata_o
// master = the core/debug side driving requests, slave = the CSR file.
// ---------------------------------------------------------------------------
interface csr_file_if;

    logic        pipe_we_i;
    logic [31:0] pipe_waddr_i;
    logic [31:0] pipe_wdata_i;
    logic [31:0] pipe_raddr_i;
    logic [31:0] pipe_rdata_o;

    logic        excep_we_i;
    logic [31:0] excep_waddr_i;
    logic [31:0] excep_wdata_i;

    logic        dbg_we_i;
    logic [31:0] dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic [31:0] dbg_rdata_o;

    modport master (
        output pipe_we_i, pipe_waddr_i, pipe_wdata_i, pipe_raddr_i,
        input  pipe_rdata_o,
        output excep_we_i, excep_waddr_i, excep_wdata_i,
        output dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_rdata_o
    );

    modport slave (
        input  pipe_we_i, pipe_waddr_i, pipe_wdata_i, pipe_raddr_i,
        output pipe_rdata_o,
        input  excep_we_i, excep_waddr_i, excep_wdata_i,
        input  dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output dbg_rdata_o
    );

endinterface

// File: rtl/csr_counter64.sv
// ---------------------------------------------------------------------------
// csr_counter64
// 64-bit free-running event counter with independently writable halves.
//   clk, rst_n : clock, async active-low reset (counter clears to 0)
//   inc_en     : count one event this cycle
//   we_lo/we_hi: load wdata into the low/high half; a load suppresses the
//                increment of the whole counter in that cycle
//   wdata      : value to load
//   count      : current 64-bit count
// ---------------------------------------------------------------------------
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_en,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    logic [63:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (we_lo) begin
            count_q[31:0] <= wdata;
        end else if (we_hi) begin
            count_q[63:32] <= wdata;
        end else if (inc_en) begin
            // Full-width add gives the low->high carry and the 2^64 wrap.
            count_q <= count_q + 64'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file
// Machine-mode and debug CSR file with three access ports.
//   clk, rst_n       : clock, async active-low reset
//   bus              : pipeline / exception / debug ports (csr_file_if.slave)
//   inst_retire_i    : one instruction retired this cycle (minstret event)
//   irq_*_i          : raw interrupt levels reflected in mip
//   mtvec_o, mepc_o, mstatus_o, mie_o, dpc_o, dcsr_o : register values
// At most one write commits per cycle (exception > debug > pipeline); reads
// are combinational and show the pre-write value during the write cycle.
// ---------------------------------------------------------------------------
module csr_file
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    csr_file_if.slave   bus,
    input  logic        inst_retire_i,
    input  logic        irq_software_i,
    input  logic        irq_timer_i,
    input  logic        irq_external_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mstatus_o,
    output logic [31:0] mie_o,
    output logic [31:0] dpc_o,
    output logic [31:0] dcsr_o
);

    logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [31:0] dcsr_q, dpc_q, dscratch0_q, dscratch1_q;
    logic [63:0] mcycle, minstret;
    logic [31:0] mip;

    wr_src_e     wr_src;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;

    // Write arbitration: losing ports are simply dropped.
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        wr_src  = WR_NONE;
        wr_addr = '0;
        wr_data = '0;
        if (bus.excep_we_i) begin
            wr_src  = WR_EXCEP;
            wr_addr = bus.excep_waddr_i[11:0];
            wr_data = bus.excep_wdata_i;
        end else if (bus.dbg_we_i) begin
            wr_src  = WR_DBG;
            wr_addr = bus.dbg_addr_i[11:0];
            wr_data = bus.dbg_wdata_i;
        end else if (bus.pipe_we_i) begin
            wr_src  = WR_PIPE;
            wr_addr = bus.pipe_waddr_i[11:0];
            wr_data = bus.pipe_wdata_i;
        end
    end

    assign wr_en = (wr_src != WR_NONE);

    // NOTE: all CSRs are individual flops, so each one takes the async reset
    // to its architectural value; there is no RAM here that must stay unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_q   <= MSTATUS_RESET;
            mie_q       <= '0;
            mtvec_q     <= '0;
            mscratch_q  <= '0;
            mepc_q      <= '0;
            mcause_q    <= '0;
            dcsr_q      <= DCSR_RESET;
            dpc_q       <= '0;
            dscratch0_q <= '0;
            dscratch1_q <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                CSR_MSTATUS:   mstatus_q   <= (wr_data & MSTATUS_WMASK) | MSTATUS_FIXED;
                CSR_MIE:       mie_q       <= wr_data & MIE_WMASK;
                CSR_MTVEC:     mtvec_q     <= wr_data;
                CSR_MSCRATCH:  mscratch_q  <= wr_data;
                CSR_MEPC:      mepc_q      <= wr_data & EPC_WMASK;
                CSR_MCAUSE:    mcause_q    <= wr_data;
                CSR_DPC:       dpc_q       <= wr_data & EPC_WMASK;
                CSR_DSCRATCH0: dscratch0_q <= wr_data;
                CSR_DSCRATCH1: dscratch1_q <= wr_data;
                CSR_DCSR: begin
                    if (wr_src == WR_EXCEP) begin
                        dcsr_q <= (wr_data & DCSR_EXC_WMASK) | DCSR_FIXED;
                    end else begin
                        dcsr_q <= (dcsr_q & ~DCSR_DBG_WMASK) | (wr_data & DCSR_DBG_WMASK);
                    end
                end
                // Read-only and unmapped addresses; counters are handled below.
                default: ;
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (1'b1),
        .we_lo  (wr_en && (wr_addr == CSR_MCYCLE)),
        .we_hi  (wr_en && (wr_addr == CSR_MCYCLEH)),
        .wdata  (wr_data),
        .count  (mcycle)
    );

    csr_counter64 u_minstret (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (inst_retire_i),
        .we_lo  (wr_en && (wr_addr == CSR_MINSTRET)),
        .we_hi  (wr_en && (wr_addr == CSR_MINSTRETH)),
        .wdata  (wr_data),
        .count  (minstret)
    );

    assign mip = {20'b0, irq_external_i, 3'b0, irq_timer_i, 3'b0, irq_software_i, 3'b0};

    csr_regs_t regs;

    always_comb begin
        regs           = '0;
        regs.mstatus   = mstatus_q;
        regs.mie       = mie_q;
        regs.mtvec     = mtvec_q;
        regs.mscratch  = mscratch_q;
        regs.mepc      = mepc_q;
        regs.mcause    = mcause_q;
        regs.mip       = mip;
        regs.mcycle    = mcycle;
        regs.minstret  = minstret;
        regs.dcsr      = dcsr_q;
        regs.dpc       = dpc_q;
        regs.dscratch0 = dscratch0_q;
        regs.dscratch1 = dscratch1_q;
    end

    assign bus.pipe_rdata_o = csr_read(bus.pipe_raddr_i[11:0], regs);
    assign bus.dbg_rdata_o  = csr_read(bus.dbg_addr_i[11:0], regs);

    // Upper address bits are architecturally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.pipe_raddr_i[31:12], bus.pipe_waddr_i[31:12],
                                bus.excep_waddr_i[31:12], bus.dbg_addr_i[31:12]};

    assign mtvec_o   = mtvec_q;
    assign mepc_o    = mepc_q;
    assign mstatus_o = mstatus_q;
    assign mie_o     = mie_q;
    assign dpc_o     = dpc_q;
    assign dcsr_o    = dcsr_q;

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have `clk`, input, 1, clock; all state changes on its rising edge.
REQ-002 SHALL have `rst_n`, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have pipeline port: `pipe_we_i` in 1, `pipe_waddr_i` in 32, `pipe_wdata_i` in 32, `pipe_raddr_i` in 32, `pipe_rdata_o` out 32.
REQ-004 SHALL have exception port: `excep_we_i` in 1, `excep_waddr_i` in 32, `excep_wdata_i` in 32.
REQ-005 SHALL have debug port: `dbg_we_i` in 1, `dbg_addr_i` in 32, `dbg_wdata_i` in 32, `dbg_rdata_o` out 32.
REQ-006 SHALL have `inst_retire_i`, input, 1, one instruction retired this cycle.
REQ-007 SHALL have `irq_software_i`, `irq_timer_i`, `irq_external_i`, inputs, 1 each, raw interrupt levels (mip source).
REQ-008 SHALL have `mtvec_o`, `mepc_o`, `mstatus_o`, `mie_o`, `dpc_o`, `dcsr_o`, outputs, 32 each, direct register values.

Function
REQ-009 SHALL decode only address bits [11:0]; bits [31:12] ignored.
REQ-010 SHALL implement CSRs: mstatus 0x300, misa 0x301 (RO 0x4000_0104), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (RO), mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82, mhartid 0xF14 (RO 0), dcsr 0x7B0, dpc 0x7B1, dscratch0 0x7B2, dscratch1 0x7B3.
REQ-011 SHALL perform at most one write per cycle, priority: exception port > debug port > pipeline port; losing writes are dropped.
REQ-012 SHALL commit writes on the next rising edge; reads combinational, returning the pre-write value in the write cycle (no forwarding).
REQ-013 SHALL return 0 for reads of unmapped addresses and ignore writes to unmapped or RO addresses.
REQ-014 SHALL make mstatus writable only in bits 3 (MIE) and 7 (MPIE); bits 12:11 (MPP) read 2'b11; other bits read 0.
REQ-015 SHALL make mie writable only in bits 3, 7, 11.
REQ-016 SHALL read mip as {20'b0, irq_external_i, 3'b0, irq_timer_i, 3'b0, irq_software_i, 3'b0}.
REQ-017 SHALL force mepc[0] and dpc[0] to 0 on any write.
REQ-018 SHALL, for dcsr writes from pipeline/debug ports, update only bits 15 (ebreakm) and 2 (step); exception-port writes update bits 31:0 except 31:28 (xdebugver, fixed 4) and 1:0 (prv, fixed 3).
REQ-019 SHALL increment 64-bit mcycle every cycle, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0 with carry from low to high half.
REQ-020 SHALL increment 64-bit minstret when `inst_retire_i`=1, same wrap rule.
REQ-021 SHALL, on a write to a counter half, load the written value into that half and suppress that cycle's increment for the whole 64-bit counter.
REQ-022 SHALL drive `dbg_rdata_o` from `dbg_addr_i` with the same decode as `pipe_rdata_o`.

Reset
REQ-023 SHALL on `rst_n`=0 set: mstatus 0x0000_1800, mie 0, mtvec 0, mscratch 0, mepc 0, mcause 0, mcycle 0, minstret 0, dcsr 0x4000_0003, dpc 0, dscratch0/1 0.
REQ-024 SHALL hold all outputs at reset values while `rst_n`=0, and ignore all write inputs during reset.

Structure
REQ-025 SHALL take CSR address constants, reset values and writable-bit masks from the shared package `csr_pkg`.
REQ-026 SHALL instantiate sub-module `csr_counter64` twice (mcycle, minstret): 64-bit counter, increment enable, split low/high write.

Verification
REQ-027 Reset, then read 0x300, 0x7B0, 0xF14 -> 0x0000_1800, 0x4000_0003, 0.
REQ-028 Same cycle: `excep_we_i` 0x342 <= 0x8000_000B and `pipe_we_i` 0x340 <= 0x1234 -> mcause=0x8000_000B, mscratch unchanged 0.
REQ-029 Pipeline write 0x341 <= 0x8000_0003 -> mepc_o=0x8000_0002 next cycle; read in write cycle returns old value.
REQ-030 Write mcycle=0xFFFF_FFFE, mcycleh=0xFFFF_FFFF -> after two further cycles counter reads 0x0 with mcycleh 0.
REQ-031 Pipeline write 0x7B0 <= 0xFFFF_FFFF -> dcsr_o=0x4000_8007; exception write 0x7B0 <= 0x0000_00C0 -> 0x4000_00C3.
REQ-032 Assert `rst_n` low mid-write of mtvec <= 0x100 -> mtvec_o=0 and stays 0 after release.
